// File: rtl/comp_mult_drv.sv
// comp_mult_drv: initiator-side driver for the complex multiplier's val-rdy interface.
// Packs four upstream words into one operand transaction and returns the result as xr then yr.
module comp_mult_drv #(
    parameter int DWIDTH    = 8,
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sw_rst,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic [DWIDTH-1:0]         in_data,
    output logic                      op_val,
    input  logic                      op_rdy,
    output logic [4*DWIDTH-1:0]       op_data,
    input  logic                      res_val,
    output logic                      res_rdy,
    input  logic [4*(DWIDTH+1)-1:0]   res_data,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [2*(DWIDTH+1)-1:0]   out_data,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      txn_cnt,
    output logic                      err
);
    localparam int RW = 2*(DWIDTH+1);
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] TLIM = WW'(TIMEOUT > 0 ? TIMEOUT-1 : 0);

    typedef enum logic [2:0] {COLLECT, ISSUE, WAIT, SEND_RE, SEND_IM} state_t;

    state_t          state;
    logic [1:0]      idx;
    logic [2*RW-1:0] res;
    logic [WW-1:0]   wd;

    assign in_rdy   = state == COLLECT;
    assign op_val   = state == ISSUE;
    assign res_rdy  = state == WAIT;
    assign out_val  = state == SEND_RE || state == SEND_IM;
    assign busy     = state != COLLECT || idx != 2'd0;
    assign out_data = state == SEND_RE ? res[2*RW-1:RW] : state == SEND_IM ? res[RW-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            idx     <= 2'd0;
            op_data <= '0;
            res     <= '0;
            wd      <= '0;
            txn_cnt <= '0;
            err     <= 1'b0;
        end else if (sw_rst) begin
            state   <= COLLECT;
            idx     <= 2'd0;
            op_data <= '0;
            res     <= '0;
            wd      <= '0;
            txn_cnt <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                COLLECT: if (in_val) begin
                    // word 0 (x1) lands in the MSBs
                    op_data[(3-int'(idx))*DWIDTH +: DWIDTH] <= in_data;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= ISSUE;
                end
                ISSUE: if (op_rdy) begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // a result arriving in the limit cycle still wins over the timeout
                    if (res_val) begin
                        res   <= res_data;
                        state <= SEND_RE;
                    end else if (TIMEOUT != 0 && wd == TLIM) begin
                        err   <= 1'b1;
                        state <= COLLECT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                SEND_RE: if (out_rdy) state <= SEND_IM;
                SEND_IM: if (out_rdy) begin
                    txn_cnt <= txn_cnt + 1'b1;
                    state   <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_comp_mult_drv.sv
// tb_comp_mult_drv: directed and randomized transactions against a complex-multiply reference.
module tb_comp_mult_drv;
    localparam int D = 8, TO = 16, CW = 4, RW = 2*(D+1);

    logic clk = 1'b0, rst_n = 1'b0, sw_rst = 1'b0;
    logic in_val = 1'b0, op_rdy = 1'b0, res_val = 1'b0, out_rdy = 1'b0;
    logic [D-1:0] in_data = '0;
    logic [2*RW-1:0] res_data = '0;
    logic in_rdy, op_val, res_rdy, out_val, busy, err;
    logic [4*D-1:0] op_data;
    logic [RW-1:0] out_data;
    logic [CW-1:0] txn_cnt;

    int errors = 0, checks = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic exp_err = 1'b0;

    comp_mult_drv #(.DWIDTH(D), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
        .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
        .op_val(op_val), .op_rdy(op_rdy), .op_data(op_data),
        .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .busy(busy), .txn_cnt(txn_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [D-1:0] d);
        int n = 0;
        in_val = 1'b1;
        in_data = d;
        while (!in_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_rdy_wait", in_rdy, 1);
        @(negedge clk);
        in_val = 1'b0;
    endtask

    // Reference: signed complex product (w0 + j*w1) * (w2 + j*w3), each part RW bits.
    task automatic txn(input logic [D-1:0] w0, w1, w2, w3,
                       input int op_st, res_dl, out_st, input bit timeout);
        int a, b, c, e;
        logic [RW-1:0] xr, yr;
        a = int'($signed(w0)); b = int'($signed(w1));
        c = int'($signed(w2)); e = int'($signed(w3));
        xr = RW'(a*c - b*e);
        yr = RW'(a*e + b*c);
        put(w0); put(w1); put(w2); put(w3);
        chk("op_val_rise", op_val, 1);
        chk("op_data", op_data, {w0, w1, w2, w3});
        for (int i = 0; i < op_st; i++) begin
            @(negedge clk);
            chk("op_val_hold", op_val, 1);
            chk("op_data_hold", op_data, {w0, w1, w2, w3});
            chk("in_rdy_issue", in_rdy, 0);
        end
        op_rdy = 1'b1;
        @(negedge clk);
        op_rdy = 1'b0;
        chk("op_val_drop", op_val, 0);
        if (timeout) begin
            for (int i = 0; i < TO; i++) begin
                chk("res_rdy_wait", res_rdy, 1);
                chk("err_before_to", err, exp_err);
                @(negedge clk);
            end
            exp_err = 1'b1;
            chk("err_timeout", err, 1);
            chk("in_rdy_after_to", in_rdy, 1);
            chk("busy_after_to", busy, 0);
            chk("txn_cnt_after_to", txn_cnt, exp_cnt);
            return;
        end
        for (int i = 0; i < res_dl; i++) begin
            chk("res_rdy_wait", res_rdy, 1);
            @(negedge clk);
        end
        chk("res_rdy", res_rdy, 1);
        res_val = 1'b1;
        res_data = {xr, yr};
        @(negedge clk);
        res_val = 1'b0;
        res_data = '0;
        chk("out_val_re", out_val, 1);
        chk("out_xr", out_data, xr);
        for (int i = 0; i < out_st; i++) begin
            @(negedge clk);
            chk("out_val_hold", out_val, 1);
            chk("out_xr_hold", out_data, xr);
            chk("in_rdy_send", in_rdy, 0);
            chk("busy_send", busy, 1);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        chk("out_val_im", out_val, 1);
        chk("out_yr", out_data, yr);
        @(negedge clk);
        out_rdy = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        chk("out_val_done", out_val, 0);
        chk("in_rdy_done", in_rdy, 1);
        chk("busy_done", busy, 0);
        chk("txn_cnt", txn_cnt, exp_cnt);
        chk("err_sticky", err, exp_err);
    endtask

    function automatic logic [D-1:0] rw();
        return D'($urandom);
    endfunction

    initial begin
        logic [CW-1:0] c0;
        #1;
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_op_val", op_val, 0);
        chk("rst_res_rdy", res_rdy, 0);
        chk("rst_out_val", out_val, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn_cnt", txn_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_op_data", op_data, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        txn(8'h03, 8'h04, 8'h02, 8'hFF, 0, 0, 0, 0);
        txn(8'h80, 8'h00, 8'h80, 8'h00, 0, 2, 0, 0);
        txn(rw(), rw(), rw(), rw(), 7, 1, 0, 0);
        txn(rw(), rw(), rw(), rw(), 0, 0, 5, 0);
        txn(rw(), rw(), rw(), rw(), 0, TO-1, 0, 0);
        txn(rw(), rw(), rw(), rw(), 0, 0, 0, 1);
        txn(rw(), rw(), rw(), rw(), 1, 3, 2, 0);

        // software reset mid-collection clears everything, including err
        put(rw()); put(rw());
        chk("busy_partial", busy, 1);
        sw_rst = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        exp_cnt = '0;
        exp_err = 1'b0;
        chk("swrst_busy", busy, 0);
        chk("swrst_in_rdy", in_rdy, 1);
        chk("swrst_err", err, 0);
        chk("swrst_txn_cnt", txn_cnt, 0);
        txn(8'hA5, 8'h11, 8'h7F, 8'h80, 0, 0, 0, 0);

        c0 = exp_cnt;
        for (int k = 0; k < 16; k++)
            txn(rw(), rw(), rw(), rw(), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
        chk("txn_cnt_wrap", txn_cnt, c0);

        // asynchronous reset in the middle of collection
        put(rw()); put(rw()); put(rw());
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_op_data", op_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        txn(8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
